// File: rtl/sprite_pkg.sv
// Shared types and constants for the character sprite pipeline.
package sprite_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WALK = 1'b1
   } anim_state_t;

   localparam int unsigned SPR_W_DEF = 32;
   localparam int unsigned SPR_H_DEF = 48;

   localparam logic [1:0] FRAME_STAND = 2'd0;
   localparam logic [1:0] FRAME_WALK1 = 2'd1;

endpackage

// File: rtl/vsync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle pulse
// on its synchronized rising edge.
module vsync_edge (
   input  logic Clk,
   input  logic Reset,
   input  logic async_in,
   output logic tick
);

   logic r_sync1;
   logic r_sync2;
   logic r_sync3;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= async_in;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign tick = r_sync2 & ~r_sync3;

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Per-pixel sprite ROM addressing, ROM-latency realignment and walk-cycle
// animation stepped on vertical-sync boundaries.
module sprite_anim_sequencer
   import sprite_pkg::*;
#(
   parameter int unsigned SPR_W       = SPR_W_DEF,
   parameter int unsigned SPR_H       = SPR_H_DEF,
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned HOLD_FRAMES = 6,
   parameter int unsigned NUM_WALK    = 3
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              frame_clk,
   input  logic              moving,
   input  logic              facing_left,
   input  logic [9:0]        sprite_x,
   input  logic [9:0]        sprite_y,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [1:0]        frame_sel,
   input  logic [1:0]        rom_data,
   output logic              sprite_on,
   output logic [1:0]        sprite_pixel
);

   localparam int unsigned COL_W  = $clog2(SPR_W);
   localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

   logic                    w_tick;
   logic signed [10:0]      w_dx;
   logic signed [10:0]      w_dy;
   logic                    w_inside;
   logic [COL_W-1:0]        w_col;
   logic [ADDR_W-1:0]       w_addr;

   logic [ADDR_W-1:0]       r_addr;
   logic                    r_inside_d;
   logic                    r_on;
   logic [1:0]              r_pixel;
   logic                    r_facing;

   anim_state_t             r_state;
   anim_state_t             w_state_nxt;
   logic [HOLD_W-1:0]       r_hold;
   logic [HOLD_W-1:0]       w_hold_nxt;
   logic [1:0]              r_frame;
   logic [1:0]              w_frame_nxt;

   vsync_edge u_vsync_edge (
      .Clk      (Clk),
      .Reset    (Reset),
      .async_in (frame_clk),
      .tick     (w_tick)
   );

   // Zero-extended 11-bit subtraction: a draw position left of or above the
   // origin shows up as a set sign bit and is rejected, never wrapped inside.
   assign w_dx = $signed({1'b0, DrawX}) - $signed({1'b0, sprite_x});
   assign w_dy = $signed({1'b0, DrawY}) - $signed({1'b0, sprite_y});

   assign w_inside = (w_dx[10] == 1'b0) && (w_dx[9:0] < 10'(SPR_W)) &&
                     (w_dy[10] == 1'b0) && (w_dy[9:0] < 10'(SPR_H));

   assign w_col  = r_facing ? (COL_W'(SPR_W - 1) - w_dx[COL_W-1:0]) : w_dx[COL_W-1:0];
   assign w_addr = (ADDR_W'(w_dy[9:0]) << COL_W) | ADDR_W'(w_col);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_addr     <= '0;
         r_inside_d <= 1'b0;
         r_on       <= 1'b0;
         r_pixel    <= '0;
      end else begin
         r_addr     <= w_inside ? w_addr : '0;
         r_inside_d <= w_inside;
         r_pixel    <= rom_data;
         r_on       <= r_inside_d && (rom_data != 2'd0);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state  <= IDLE;
         r_hold   <= '0;
         r_frame  <= FRAME_STAND;
         r_facing <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_hold   <= w_hold_nxt;
         r_frame  <= w_frame_nxt;
         if (w_tick) begin
            r_facing <= facing_left;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_frame_nxt = r_frame;
      if (w_tick) begin
         case (r_state)
            IDLE: begin
               if (moving) begin
                  w_state_nxt = WALK;
                  w_frame_nxt = FRAME_WALK1;
                  w_hold_nxt  = '0;
               end
            end
            WALK: begin
               if (!moving) begin
                  w_state_nxt = IDLE;
                  w_frame_nxt = FRAME_STAND;
                  w_hold_nxt  = '0;
               end else if (r_hold == HOLD_W'(HOLD_FRAMES - 1)) begin
                  w_hold_nxt  = '0;
                  w_frame_nxt = (r_frame == 2'(NUM_WALK)) ? FRAME_WALK1 : r_frame + 2'd1;
               end else begin
                  w_hold_nxt  = r_hold + HOLD_W'(1);
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_frame_nxt = FRAME_STAND;
               w_hold_nxt  = '0;
            end
         endcase
      end
   end

   always_comb begin
      frame_sel    = (r_state == WALK) ? r_frame : FRAME_STAND;
      rom_addr     = r_addr;
      sprite_on    = r_on;
      sprite_pixel = r_pixel;
   end

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Randomized and directed bench for sprite_anim_sequencer against a
// behavioural model of the hit test, addressing and walk cadence.
module tb_sprite_anim_sequencer;

   localparam int SPR_W = 32;
   localparam int SPR_H = 48;
   localparam int HOLD  = 6;
   localparam int NW    = 3;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        frame_clk;
   logic        moving;
   logic        facing_left;
   logic [9:0]  sprite_x;
   logic [9:0]  sprite_y;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic [10:0] rom_addr;
   logic [1:0]  frame_sel;
   logic [1:0]  rom_data;
   logic        sprite_on;
   logic [1:0]  sprite_pixel;

   logic [1:0]  rom [0:1535];

   int n_checks = 0;
   int n_pass   = 0;

   // model state
   bit m_facing  = 1'b0;
   bit m_walking = 1'b0;
   int m_ticks   = 0;
   int m_frame   = 0;

   // pixel pipeline history: h1 = driven one cycle ago, h2 = two cycles ago
   bit h1_v = 1'b0, h2_v = 1'b0;
   bit h1_i = 1'b0, h2_i = 1'b0;
   int h1_a = 0,    h2_a = 0;

   sprite_anim_sequencer #(
      .SPR_W       (SPR_W),
      .SPR_H       (SPR_H),
      .ADDR_W      (11),
      .HOLD_FRAMES (HOLD),
      .NUM_WALK    (NW)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .frame_clk    (frame_clk),
      .moving       (moving),
      .facing_left  (facing_left),
      .sprite_x     (sprite_x),
      .sprite_y     (sprite_y),
      .DrawX        (DrawX),
      .DrawY        (DrawY),
      .rom_addr     (rom_addr),
      .frame_sel    (frame_sel),
      .rom_data     (rom_data),
      .sprite_on    (sprite_on),
      .sprite_pixel (sprite_pixel)
   );

   always #5 Clk = ~Clk;

   // ROM data for an address is ready by the next Clk edge
   always_comb begin
      rom_data = 2'd0;
      if (rom_addr < 11'd1536) rom_data = rom[rom_addr];
   end

   task automatic chk(input string tag, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   task automatic pix_step(input logic [9:0] x, input logic [9:0] y);
      int dxi, dyi;
      bit ins;
      @(negedge Clk);
      if (h1_v) chk("rom_addr", int'(rom_addr), h1_a);
      if (h2_v) begin
         chk("sprite_pixel", int'(sprite_pixel), int'(rom[h2_a]));
         chk("sprite_on", int'(sprite_on), (h2_i && rom[h2_a] != 2'd0) ? 1 : 0);
      end
      h2_v = h1_v; h2_a = h1_a; h2_i = h1_i;
      DrawX = x;
      DrawY = y;
      dxi = int'(x) - int'(sprite_x);
      dyi = int'(y) - int'(sprite_y);
      ins = (dxi >= 0) && (dxi < SPR_W) && (dyi >= 0) && (dyi < SPR_H);
      h1_v = 1'b1;
      h1_i = ins;
      h1_a = ins ? (dyi * SPR_W + (m_facing ? (SPR_W - 1 - dxi) : dxi)) : 0;
   endtask

   task automatic directed(input string tag, input int sx, input int sy, input int x,
                           input int y, input int exp_a, input bit exp_in, input logic [1:0] rv);
      sprite_x = 10'(sx);
      sprite_y = 10'(sy);
      if (exp_in) rom[exp_a] = rv;
      h1_v = 1'b0;
      h2_v = 1'b0;
      repeat (3) pix_step(10'(x), 10'(y));
      chk({tag, "_addr"}, int'(rom_addr), exp_a);
      chk({tag, "_on"}, int'(sprite_on), (exp_in && rv != 2'd0) ? 1 : 0);
      if (exp_in) chk({tag, "_pix"}, int'(sprite_pixel), int'(rv));
   endtask

   task automatic do_tick();
      logic mv, fl;
      @(negedge Clk);
      frame_clk = 1'b1;
      repeat (2) begin
         @(negedge Clk);
         chk("frame_sel_pre_tick", int'(frame_sel), m_frame);
      end
      if (moving) begin
         if (!m_walking) begin
            m_walking = 1'b1;
            m_ticks   = 0;
         end else begin
            m_ticks++;
         end
         m_frame = 1 + (m_ticks / HOLD) % NW;
      end else begin
         m_walking = 1'b0;
         m_frame   = 0;
      end
      m_facing = facing_left;
      @(negedge Clk);
      chk("frame_sel_tick", int'(frame_sel), m_frame);
      @(negedge Clk);
      frame_clk = 1'b0;
      mv = moving;
      fl = facing_left;
      repeat (4) begin
         @(negedge Clk);
         moving      = 1'($urandom);
         facing_left = 1'($urandom);
         chk("frame_sel_between", int'(frame_sel), m_frame);
      end
      moving      = mv;
      facing_left = fl;
   endtask

   initial begin
      Reset       = 1'b1;
      frame_clk   = 1'b0;
      moving      = 1'b0;
      facing_left = 1'b0;
      sprite_x    = '0;
      sprite_y    = '0;
      DrawX       = '0;
      DrawY       = '0;
      for (int i = 0; i < 1536; i++) rom[i] = 2'($urandom);

      repeat (3) @(negedge Clk);
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_frame_sel", int'(frame_sel), 0);
      chk("rst_sprite_on", int'(sprite_on), 0);
      chk("rst_sprite_pixel", int'(sprite_pixel), 0);
      Reset = 1'b0;

      // hit test, addressing, boundaries, transparency
      directed("base",    100, 200, 105, 210,  325, 1'b1, 2'd2);
      directed("transp",  100, 200, 105, 210,  325, 1'b1, 2'd0);
      directed("left_out", 100, 200,  99, 210,    0, 1'b0, 2'd0);
      directed("right_in", 100, 200, 131, 210,  351, 1'b1, 2'd1);
      directed("right_out",100, 200, 132, 210,    0, 1'b0, 2'd0);
      directed("bot_in",  100, 200, 105, 247, 1509, 1'b1, 2'd3);
      directed("bot_out", 100, 200, 105, 248,    0, 1'b0, 2'd0);
      directed("underflow", 5,   0,   2,  10,    0, 1'b0, 2'd0);

      // mirror latched only on a tick
      facing_left = 1'b1;
      moving      = 1'b0;
      do_tick();
      directed("mirror",      100, 200, 105, 210, 346, 1'b1, 2'd1);
      facing_left = 1'b0;
      directed("mirror_hold", 100, 200, 105, 210, 346, 1'b1, 2'd3);
      do_tick();

      // walk cadence: 20 ticks, then drop moving
      moving = 1'b1;
      for (int t = 0; t < 20; t++) do_tick();
      moving = 1'b0;
      do_tick();
      chk("stand_after_walk", int'(frame_sel), 0);

      // randomized sprite placement, facing and walk requests
      for (int k = 0; k < 8; k++) begin
         sprite_x    = 10'($urandom_range(0, 1023));
         sprite_y    = 10'($urandom_range(0, 1023));
         facing_left = 1'($urandom);
         moving      = 1'($urandom);
         do_tick();
         h1_v = 1'b0;
         h2_v = 1'b0;
         for (int p = 0; p < 40; p++)
            pix_step(10'(int'(sprite_x) + int'($urandom_range(0, 40)) - 4),
                     10'(int'(sprite_y) + int'($urandom_range(0, 56)) - 4));
         pix_step(DrawX, DrawY);
         pix_step(DrawX, DrawY);
      end

      // asynchronous reset in the middle of a walk
      facing_left = 1'b0;
      moving      = 1'b0;
      do_tick();
      moving = 1'b1;
      for (int t = 0; t < 7; t++) do_tick();
      chk("pre_reset_frame", int'(frame_sel), 2);
      directed("pre_reset", 100, 200, 105, 210, 325, 1'b1, 2'd3);
      @(negedge Clk);
      #2 Reset = 1'b1;
      #1;
      chk("reset_frame_sel", int'(frame_sel), 0);
      chk("reset_sprite_on", int'(sprite_on), 0);
      chk("reset_rom_addr", int'(rom_addr), 0);
      m_walking = 1'b0;
      m_frame   = 0;
      m_facing  = 1'b0;
      repeat (2) @(negedge Clk);
      Reset  = 1'b0;
      moving = 1'b0;
      do_tick();
      chk("post_reset_idle", int'(frame_sel), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
